uart_tx_arb: RTL and testbench

Round-robin arbiter that lets up to NREQ byte-stream requesters (CPU-side FIFOs, debug monitor, burst engine) share one UART transmitter holding register. It sits between the requesters and the `wrtx`/`d`/`thre` port of a UART core. It paces writes off `thre`, so no requester needs to see UART status. An optional packet-lock mode keeps the grant with one requester until it marks the last byte, so multi-byte frames are never interleaved.

---
 rtl/uart_tx_arb_if.sv | 16 +
 rtl/uart_tx_arb.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// Requester-side bundle for uart_tx_arb: per-requester byte valid, data,
// end-of-packet marker, and the arbiter's ack/grant responses.
interface uart_tx_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   last;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   gnt;

  // Requesters drive bytes and observe ack/gnt.
  modport master (output req, data, last, input ack, gnt);
  // The arbiter consumes bytes and returns ack/gnt.
  modport slave  (input req, data, last, output ack, gnt);
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART TX holding register
// among NREQ byte-stream requesters, paced by uart_thre.
// Optional packet lock: define UART_TX_ARB_PKTLOCK_EN to keep the grant with
// one requester until it writes a byte marked last (abort on early drop).
module uart_tx_arb #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_tx_arb_if.slave    rq,
  output logic            uart_wrtx,
  output logic [7:0]      uart_d,
  input  logic            uart_thre,
  output logic            busy,
  output logic            abort,
  output logic [CNTW-1:0] tx_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef UART_TX_ARB_PKTLOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   owner_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [NREQ-1:0] ack_reg;
  logic            wrtx_reg;
  logic [7:0]      d_reg;
  logic            abort_reg;
  logic            last_wr_reg;
  logic            in_pkt_reg;
  logic [CNTW-1:0] cnt_reg;

  logic [7:0]      byte_w [NREQ];
  logic [PW-1:0]   win_idx;
  logic            win_found;
  logic [PW:0]     rr_pos;
  logic [PW-1:0]   owner_inc;

  // Slice the packed data bus into one byte per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_byte
      assign byte_w[gi] = rq.data[8*gi +: 8];
    end
  endgenerate

  // Round-robin search: first asserted req at or after ptr, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_pos    = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_pos = {1'b0, ptr_reg} + (PW+1)'(k);
      if (rr_pos >= (PW+1)'(NREQ)) rr_pos = rr_pos - (PW+1)'(NREQ);
      if (!win_found && rq.req[rr_pos[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_pos[PW-1:0];
      end
    end
  end

  // Pointer value that gives the next requester after the owner first chance.
  assign owner_inc = (owner_reg == PW'(NREQ-1)) ? '0 : owner_reg + 1'b1;

  // Arbiter FSM with all handshake and UART outputs registered.
  // GUARD is entered together with the write strobe; the strobe cycle itself
  // is spent waiting, and the following cycle (where uart_thre may still
  // read high from before the write) makes the hold/release decision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      owner_reg   <= '0;
      gnt_reg     <= '0;
      ack_reg     <= '0;
      wrtx_reg    <= 1'b0;
      d_reg       <= 8'h00;
      abort_reg   <= 1'b0;
      last_wr_reg <= 1'b0;
      in_pkt_reg  <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      wrtx_reg  <= 1'b0;
      ack_reg   <= '0;
      abort_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            gnt_reg    <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            owner_reg  <= win_idx;
            in_pkt_reg <= 1'b0;
            state_reg  <= GRANT;
          end
        end
        GRANT: begin
          if (rq.req[owner_reg]) begin
            if (uart_thre) begin
              wrtx_reg    <= 1'b1;
              d_reg       <= byte_w[owner_reg];
              ack_reg     <= gnt_reg;
              last_wr_reg <= rq.last[owner_reg];
              if (cnt_reg != {CNTW{1'b1}}) cnt_reg <= cnt_reg + 1'b1;
              state_reg   <= GUARD;
            end
          end else begin
            // Owner withdrew; only an open locked packet counts as an abort.
            abort_reg  <= in_pkt_reg;
            gnt_reg    <= '0;
            ptr_reg    <= owner_inc;
            in_pkt_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        GUARD: begin
          if (!wrtx_reg) begin
            if (LOCK_EN && !last_wr_reg) begin
              in_pkt_reg <= 1'b1;
              state_reg  <= GRANT;
            end else begin
              gnt_reg    <= '0;
              ptr_reg    <= owner_inc;
              in_pkt_reg <= 1'b0;
              state_reg  <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rq.gnt    = gnt_reg;
  assign rq.ack    = ack_reg;
  assign uart_wrtx = wrtx_reg;
  assign uart_d    = d_reg;
  assign abort     = abort_reg;
  assign tx_count  = cnt_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: directed scenarios plus randomized requester
// traffic; a monitor scoreboards every UART write against per-requester
// expected-byte queues and a round-robin grant model.
module tb_uart_tx_arb;
  localparam int NREQ = 4;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            uart_thre;
  logic            uart_wrtx;
  logic [7:0]      uart_d;
  logic            busy;
  logic            abort;
  logic [CNTW-1:0] tx_count;

  uart_tx_arb_if #(.NREQ(NREQ)) bus ();

  uart_tx_arb #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rq       (bus),
    .uart_wrtx(uart_wrtx),
    .uart_d   (uart_d),
    .uart_thre(uart_thre),
    .busy     (busy),
    .abort    (abort),
    .tx_count (tx_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q [NREQ][$];
  logic [7:0] wlog[$];
  int         wtime[$];
  int         n_abort = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rule: first pending requester at or after the pointer.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Monitor / scoreboard
  logic [NREQ-1:0] prev_gnt  = '0;
  logic            prev_wrtx = 1'b0;
  int              m_ptr     = 0;
  int              m_owner   = -1;
  logic [CNTW-1:0] m_count   = '0;

  always @(posedge clk) begin
    logic [NREQ-1:0] exp_g;
    #1;
    if (!reset_n) begin
      prev_gnt  = '0;
      prev_wrtx = 1'b0;
      m_ptr     = 0;
      m_owner   = -1;
      m_count   = '0;
    end else begin
      if (bus.gnt != '0 && prev_gnt == '0) begin
        m_owner = rr_pick(bus.req, m_ptr);
        exp_g   = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
        chk("grant_pick", 32'(bus.gnt), 32'(exp_g));
      end else if (prev_gnt != '0 && bus.gnt == '0) begin
        m_ptr = (m_owner + 1) % NREQ;
      end else if (prev_gnt != '0 && bus.gnt != prev_gnt) begin
        chk("grant_stable", 32'(bus.gnt), 32'(prev_gnt));
      end
      if (uart_wrtx) begin
        chk("wrtx_gap", 32'(prev_wrtx), 32'(0));
        chk("ack_owner", 32'(bus.ack), 32'(prev_gnt));
        if (m_owner >= 0) begin
          chk("sb_nonempty", 32'(exp_q[m_owner].size() != 0), 32'(1));
          if (exp_q[m_owner].size() != 0)
            chk("uart_d", 32'(uart_d), 32'(exp_q[m_owner].pop_front()));
        end
        if (m_count != {CNTW{1'b1}}) m_count = m_count + 1'b1;
        chk("tx_count", 32'(tx_count), 32'(m_count));
        wlog.push_back(uart_d);
        wtime.push_back(cyc);
      end else begin
        chk("ack_idle", 32'(bus.ack), 32'(0));
      end
      if (abort) n_abort++;
      prev_gnt  = bus.gnt;
      prev_wrtx = uart_wrtx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    wlog.delete();
    wtime.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    bus.req  = '0;
    bus.data = '0;
    bus.last = '0;
    clear_sb();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rr_exp [5];
    int n0;
    int left [NREQ];
    int gap  [NREQ];
    int pushed;
    int ab0;
    logic [7:0] b;

    reset_n   = 1'b0;
    uart_thre = 1'b1;
    bus.req   = '0;
    bus.data  = '0;
    bus.last  = '0;

    // Reset state
    do_reset();
    tick();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wrtx", 32'(uart_wrtx), 0);
    chk("rst_txcnt", 32'(tx_count), 0);
    chk("rst_d", 32'(uart_d), 0);
    chk("rst_abort", 32'(abort), 0);

    // Single requester: grant in cycle 1, write in cycle 2
    do_reset();
    @(negedge clk);
    bus.req[0] = 1'b1; bus.data[7:0] = 8'h41; bus.last[0] = 1'b1;
    exp_q[0].push_back(8'h41);
    tick();
    chk("single_gnt", 32'(bus.gnt), 32'h1);
    chk("single_busy", 32'(busy), 1);
    tick();
    chk("single_wrtx", 32'(uart_wrtx), 1);
    chk("single_d", 32'(uart_d), 32'h41);
    chk("single_ack", 32'(bus.ack), 32'h1);
    chk("single_cnt", 32'(tx_count), 1);
    @(negedge clk);
    bus.req = '0;
    repeat (4) tick();

    // Round robin, all four requesters held
    do_reset();
    rr_exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
    @(negedge clk);
    bus.data = {8'h40, 8'h30, 8'h20, 8'h10};
    bus.last = '1;
    bus.req  = '1;
    exp_q[0].push_back(8'h10); exp_q[0].push_back(8'h10);
    exp_q[1].push_back(8'h20); exp_q[2].push_back(8'h30); exp_q[3].push_back(8'h40);
    for (int t = 0; t < 60 && wlog.size() < 5; t++) tick();
    @(negedge clk);
    bus.req = '0;
    chk("rr_writes", 32'(wlog.size()), 5);
    if (wlog.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 32'(wlog[i]), 32'(rr_exp[i]));
      for (int i = 1; i < 5; i++) chk($sformatf("rr_space%0d", i), 32'(wtime[i] - wtime[i-1]), 4);
    end
    repeat (6) tick();

    // Flow control: no write while uart_thre is low
    do_reset();
    @(negedge clk);
    uart_thre  = 1'b0;
    bus.req[1] = 1'b1; bus.data[15:8] = 8'h77; bus.last[1] = 1'b1;
    exp_q[1].push_back(8'h77);
    n0 = wlog.size();
    repeat (50) tick();
    chk("flow_nowrite", 32'(wlog.size()), 32'(n0));
    chk("flow_gnt", 32'(bus.gnt), 32'h2);
    @(negedge clk);
    uart_thre = 1'b1;
    tick();
    chk("flow_wrtx", 32'(uart_wrtx), 1);
    chk("flow_d", 32'(uart_d), 32'h77);
    @(negedge clk);
    bus.req = '0;
    repeat (5) tick();
    chk("flow_once", 32'(wlog.size()), 32'(n0 + 1));

    // Reset while in GRANT (tx_count and uart_d are nonzero here)
    @(negedge clk);
    uart_thre  = 1'b0;
    bus.req[0] = 1'b1; bus.data[7:0] = 8'h99; bus.last[0] = 1'b1;
    repeat (3) tick();
    chk("mid_busy", 32'(busy), 1);
    @(negedge clk);
    reset_n = 1'b0;
    bus.req = '0;
    #1;
    chk("mid_gnt", 32'(bus.gnt), 0);
    chk("mid_ack", 32'(bus.ack), 0);
    chk("mid_wrtx", 32'(uart_wrtx), 0);
    chk("mid_d", 32'(uart_d), 0);
    chk("mid_abort", 32'(abort), 0);
    chk("mid_busy0", 32'(busy), 0);
    chk("mid_cnt", 32'(tx_count), 0);
    clear_sb();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    uart_thre  = 1'b1;
    bus.req[2] = 1'b1; bus.data[23:16] = 8'h5A; bus.last[2] = 1'b1;
    exp_q[2].push_back(8'h5A);
    tick();
    chk("post_gnt", 32'(bus.gnt), 32'h4);
    tick();
    chk("post_d", 32'(uart_d), 32'h5A);
    @(negedge clk);
    bus.req = '0;
    repeat (4) tick();

`ifdef UART_TX_ARB_PKTLOCK_EN
    // Packet lock: AA,BB,CC from req0 before req1's 55
    do_reset();
    @(negedge clk);
    bus.data = {8'h00, 8'h00, 8'h55, 8'hAA};
    bus.last = 4'b0010;
    bus.req  = 4'b0011;
    exp_q[0].push_back(8'hAA); exp_q[0].push_back(8'hBB); exp_q[0].push_back(8'hCC);
    exp_q[1].push_back(8'h55);
    n0 = 0;
    for (int t = 0; t < 80 && wlog.size() < 4; t++) begin
      @(negedge clk);
      if (bus.ack[0]) begin
        n0++;
        if (n0 == 1) bus.data[7:0] = 8'hBB;
        if (n0 == 2) begin bus.data[7:0] = 8'hCC; bus.last[0] = 1'b1; end
        if (n0 == 3) bus.req[0] = 1'b0;
      end
      if (bus.ack[1]) bus.req[1] = 1'b0;
    end
    @(negedge clk);
    bus.req = '0;
    chk("lock_writes", 32'(wlog.size()), 4);
    if (wlog.size() >= 4) begin
      chk("lock_b0", 32'(wlog[0]), 32'hAA);
      chk("lock_b1", 32'(wlog[1]), 32'hBB);
      chk("lock_b2", 32'(wlog[2]), 32'hCC);
      chk("lock_b3", 32'(wlog[3]), 32'h55);
    end
    repeat (4) tick();

    // Abort: req0 drops after a non-last byte
    do_reset();
    ab0 = n_abort;
    @(negedge clk);
    bus.data = {8'h00, 8'h00, 8'h55, 8'hAA};
    bus.last = 4'b0010;
    bus.req  = 4'b0011;
    exp_q[0].push_back(8'hAA);
    exp_q[1].push_back(8'h55);
    for (int t = 0; t < 60 && wlog.size() < 2; t++) begin
      @(negedge clk);
      if (bus.ack[0]) bus.req[0] = 1'b0;
      if (bus.ack[1]) bus.req[1] = 1'b0;
    end
    repeat (3) tick();
    chk("abort_count", 32'(n_abort - ab0), 1);
    chk("abort_txcnt", 32'(tx_count), 2);
    if (wlog.size() >= 2) chk("abort_next", 32'(wlog[1]), 32'h55);
    @(negedge clk);
    bus.req = '0;
`endif

    // Randomized traffic: packets of 1..3 bytes with random gaps and pacing
    do_reset();
    ab0    = n_abort;
    pushed = 0;
    for (int i = 0; i < NREQ; i++) begin left[i] = 0; gap[i] = $urandom_range(4); end
    for (int t = 0; t < 900; t++) begin
      @(negedge clk);
      uart_thre = ($urandom_range(3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i]) begin
          if (bus.ack[i]) begin
            if (left[i] > 0) begin
              left[i]--;
              b = 8'($urandom);
              bus.data[8*i +: 8] = b;
              bus.last[i] = (left[i] == 0);
              exp_q[i].push_back(b);
              pushed++;
            end else begin
              bus.req[i] = 1'b0;
              gap[i] = $urandom_range(6);
            end
          end
        end else if (gap[i] > 0) begin
          gap[i]--;
        end else if (t < 500) begin
          left[i] = $urandom_range(2);
          b = 8'($urandom);
          bus.data[8*i +: 8] = b;
          bus.last[i] = (left[i] == 0);
          bus.req[i]  = 1'b1;
          exp_q[i].push_back(b);
          pushed++;
        end
      end
      if (t >= 500 && bus.req == '0) break;
    end
    repeat (5) tick();
    chk("rand_drain", 32'(bus.req), 0);
    for (int i = 0; i < NREQ; i++) chk($sformatf("rand_left%0d", i), 32'(exp_q[i].size()), 0);
    chk("rand_txcnt", 32'(tx_count), 32'(pushed));
    chk("rand_noabort", 32'(n_abort - ab0), 0);
    chk("rand_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
